// File: rtl/fc_pkg.sv
// Shared definitions for the flow-control FSM and the round-robin arbiter.
// Both blocks take the channel count, the default word width and the
// arbiter state encoding from here so the two stay in step.
package fc_pkg;

  // Number of virtual-channel input FIFOs feeding the arbiter.
  localparam int NUM_VC = 4;

  // Width of the index that names one virtual channel.
  localparam int VC_IDX_W = 2;

  // Default word width of every FIFO in the datapath.
  localparam int DEFAULT_DATA_WIDTH = 6;

  // Arbiter states. Encoding 2'b11 is illegal and recovers to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } arb_state_e;

  // Index of the set bit of a one-hot (or zero) vector; zero maps to 0.
  function automatic logic [VC_IDX_W-1:0] onehot_to_idx(
    input logic [NUM_VC-1:0] oh
  );
    logic [VC_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      if (oh[i]) idx = idx | VC_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage : fc_pkg

// File: rtl/arbitro_rr_picker.sv
// Round-robin picker: chooses the first eligible channel at or above the
// pointer, wrapping 3 -> 0. Purely combinational.
module rr_picker
  import fc_pkg::*;
(
  input  logic [NUM_VC-1:0]   elig_i,
  input  logic [VC_IDX_W-1:0] ptr_i,
  output logic [NUM_VC-1:0]   gnt_o,
  output logic                any_o
);

  logic [VC_IDX_W-1:0] idx;
  logic                found;

  // Walk the channels starting at the pointer and grant the first eligible one.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    gnt_o = '0;
    found = 1'b0;
    idx   = ptr_i;
    for (int k = 0; k < NUM_VC; k++) begin
      // 2-bit addition provides the 3 -> 0 wrap for free.
      idx = ptr_i + VC_IDX_W'(k);
      if (!found && elig_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  assign any_o = |elig_i;

endmodule : rr_picker

// File: rtl/arbitro_rr.sv
// Round-robin arbiter between four virtual-channel input FIFOs and one
// output FIFO. Pops at most one word per cycle from an eligible input FIFO
// and writes it to the output FIFO two cycles later (pop -> read data ->
// registered push). In-flight words always drain; new pops are blocked by
// almost-full backpressure, by error_full, and permanently once HALT is
// entered.
module arbitro_rr
  import fc_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_VC-1:0]            pausa,
  input  logic                         error_full,
  input  logic [NUM_VC-1:0]            empty,
  input  logic [NUM_VC*DATA_WIDTH-1:0] data_in,
  input  logic                         out_full,
  input  logic                         out_almost_full,
  output logic [NUM_VC-1:0]            pop,
  output logic                         push,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic [VC_IDX_W-1:0]          grant,
  output logic                         arb_idle,
  output logic                         drop_err
);

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  arb_state_e             state_q, state_d;
  logic [VC_IDX_W-1:0]    ptr_q, ptr_d;

  // Pipeline stage: "a pop was issued last cycle" and which FIFO it hit.
  logic                   v_q;
  logic [VC_IDX_W-1:0]    sel_q;

  // Registered outputs towards the output FIFO.
  logic                   push_q;
  logic [DATA_WIDTH-1:0]  data_out_q, data_out_d;
  logic [VC_IDX_W-1:0]    grant_q;
  logic                   arb_idle_q;
  logic                   drop_err_q;

  // ---------------------------------------------------------------------
  // Eligibility and winner selection
  // ---------------------------------------------------------------------
  logic [NUM_VC-1:0]      elig;
  logic [NUM_VC-1:0]      pick_gnt;
  logic                   pick_any;
  logic [VC_IDX_W-1:0]    pick_idx;
  logic                   pop_ok;
  logic [DATA_WIDTH-1:0]  words [NUM_VC];

  assign elig = ~empty & ~pausa;

  rr_picker u_picker (
    .elig_i (elig),
    .ptr_i  (ptr_q),
    .gnt_o  (pick_gnt),
    .any_o  (pick_any)
  );

  assign pick_idx = onehot_to_idx(pick_gnt);

  // A pop needs an eligible FIFO, no halt, no backpressure and no overflow alarm.
  // error_full blocks the pop in the same cycle it is raised.
  assign pop_ok = pick_any && (state_q != HALT) && !out_almost_full && !error_full;

  assign pop = pop_ok ? pick_gnt : '0;

  // Pointer moves just past the popped FIFO; it holds on cycles without a pop.
  assign ptr_d = pop_ok ? pick_idx + VC_IDX_W'(1) : ptr_q;

  // Split the packed read-data bus into one word per FIFO.
  for (genvar g = 0; g < NUM_VC; g++) begin : g_words
    assign words[g] = data_in[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Capture the popped word when it becomes valid, otherwise hold the last one.
  assign data_out_d = v_q ? words[sel_q] : data_out_q;

  // ---------------------------------------------------------------------
  // FSM next-state logic
  // ---------------------------------------------------------------------
  // Next state: leave IDLE on the first allowed pop, return once fully drained,
  // and latch HALT whenever error_full is seen.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pop_ok) state_d = RUN;
      RUN:     if (!pop_ok && !v_q && !push_q) state_d = IDLE;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
    if (error_full) state_d = HALT;
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  // State register, round-robin pointer and idle flag decoded from next state.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state is updated with non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      arb_idle_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      arb_idle_q <= (state_d == IDLE);
    end
  end

  // Pipeline stage between the pop and the cycle its read data is valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q   <= 1'b0;
      sel_q <= '0;
    end else begin
      v_q <= pop_ok;
      if (pop_ok) sel_q <= pick_idx;
    end
  end

  // Output-FIFO write port: push, data and grant follow the pipeline stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      push_q     <= 1'b0;
      data_out_q <= '0;
      grant_q    <= '0;
    end else begin
      push_q     <= v_q;
      data_out_q <= data_out_d;
      if (v_q) grant_q <= sel_q;
    end
  end

  // Sticky overflow flag: a push into a full output FIFO loses the word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_err_q <= 1'b0;
    end else if (push_q && out_full) begin
      drop_err_q <= 1'b1;
    end
  end

  assign push     = push_q;
  assign data_out = data_out_q;
  assign grant    = grant_q;
  assign arb_idle = arb_idle_q;
  assign drop_err = drop_err_q;

endmodule : arbitro_rr

// File: tb/tb_arbitro_rr.sv
// Self-checking bench for arbitro_rr: directed scenarios with literal
// expectations plus a long randomized run, all compared every cycle against
// a behavioural model of the arbitration rules.
module tb_arbitro_rr;

  localparam int NV = 4;
  localparam int DW = 6;

  logic            clk = 1'b0;
  logic            reset;
  logic [NV-1:0]   pausa;
  logic            error_full;
  logic [NV-1:0]   empty;
  logic [NV*DW-1:0] data_in;
  logic            out_full;
  logic            out_almost_full;
  logic [NV-1:0]   pop;
  logic            push;
  logic [DW-1:0]   data_out;
  logic [1:0]      grant;
  logic            arb_idle;
  logic            drop_err;

  int n_checks = 0;
  int n_fail   = 0;

  arbitro_rr #(.DATA_WIDTH(DW)) dut (
    .clk             (clk),
    .reset           (reset),
    .pausa           (pausa),
    .error_full      (error_full),
    .empty           (empty),
    .data_in         (data_in),
    .out_full        (out_full),
    .out_almost_full (out_almost_full),
    .pop             (pop),
    .push            (push),
    .data_out        (data_out),
    .grant           (grant),
    .arb_idle        (arb_idle),
    .drop_err        (drop_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------
  // Behavioural model: pointer, halted/busy flags, one word "popped last
  // cycle", and the expected registered outputs for the current cycle.
  // ---------------------------------------------------------------------
  int            m_ptr;
  bit            m_halt, m_busy;
  bit            m_v1;
  int            m_sel1;
  bit            m_push;
  logic [DW-1:0] m_dout;
  int            m_grant;
  bit            m_drop;

  task automatic model_reset();
    m_ptr = 0; m_halt = 0; m_busy = 0; m_v1 = 0; m_sel1 = 0;
    m_push = 0; m_dout = '0; m_grant = 0; m_drop = 0;
  endtask

  task automatic model_check_and_step();
    logic [NV-1:0] elig;
    logic [NV-1:0] exp_pop;
    int  win;
    int  idx;
    bit  allowed;
    bit  drop_n;
    elig = ~empty & ~pausa;
    win  = -1;
    for (int k = 0; k < NV; k++) begin
      idx = (m_ptr + k) % NV;
      if (win < 0 && elig[idx]) win = idx;
    end
    allowed = (win >= 0) && !m_halt && !out_almost_full && !error_full;
    exp_pop = allowed ? (4'b0001 << win) : 4'b0000;

    check("pop",      32'(pop),      32'(exp_pop));
    check("push",     32'(push),     32'(m_push));
    check("data_out", 32'(data_out), 32'(m_dout));
    check("grant",    32'(grant),    32'(m_grant));
    check("drop_err", 32'(drop_err), 32'(m_drop));
    check("arb_idle", 32'(arb_idle), 32'(!m_halt && !m_busy));

    drop_n = m_drop | (m_push & out_full);
    if (error_full) m_halt = 1;
    else if (!m_halt) begin
      if (!m_busy && allowed) m_busy = 1;
      else if (m_busy && !allowed && !m_v1 && !m_push) m_busy = 0;
    end
    if (m_v1) begin
      m_dout  = data_in[m_sel1*DW +: DW];
      m_grant = m_sel1;
    end
    m_push = m_v1;
    m_v1   = allowed;
    if (allowed) begin
      m_sel1 = win;
      m_ptr  = (win + 1) % NV;
    end
    m_drop = drop_n;
  endtask

  // Compare process: every cycle, away from the rising edge.
  always @(negedge clk) begin
    if (reset) model_reset();
    else       model_check_and_step();
  end

  // ---------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 time unit after the rising edge.
  // ---------------------------------------------------------------------
  task automatic step(input logic [3:0] e, input logic [3:0] p,
                      input bit af, input bit ef, input bit of);
    @(posedge clk); #1;
    empty = e; pausa = p; out_almost_full = af; error_full = ef; out_full = of;
    data_in = 24'($urandom);
  endtask

  task automatic do_reset(input logic [3:0] e, input logic [3:0] p);
    @(posedge clk); #1;
    reset = 1'b1; empty = 4'hF; pausa = 4'h0;
    out_almost_full = 1'b0; error_full = 1'b0; out_full = 1'b0;
    @(negedge clk); @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0; empty = e; pausa = p;
    data_in = 24'($urandom);
  endtask

  initial begin
    int exp_pops [6];
    int alt_pops [4];

    reset = 1'b1; empty = 4'hF; pausa = 4'h0; error_full = 1'b0;
    out_full = 1'b0; out_almost_full = 1'b0; data_in = '0;

    // Reset values while reset is held.
    @(negedge clk); @(negedge clk);
    check("rst_pop",      32'(pop),      32'h0);
    check("rst_push",     32'(push),     32'h0);
    check("rst_data_out", 32'(data_out), 32'h0);
    check("rst_grant",    32'(grant),    32'h0);
    check("rst_arb_idle", 32'(arb_idle), 32'h1);
    check("rst_drop_err", 32'(drop_err), 32'h0);

    // All four FIFOs non-empty: strict rotation, push two cycles later.
    exp_pops = '{1, 2, 4, 8, 1, 2};
    do_reset(4'h0, 4'h0);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) step(4'h0, 4'h0, 0, 0, 0);
      @(negedge clk);
      check("rot_pop", 32'(pop), 32'(exp_pops[k]));
      check("rot_push", 32'(push), 32'(k >= 2));
      if (k >= 2) check("rot_grant", 32'(grant), 32'(k - 2));
    end

    // Only FIFO 2 non-empty: popped every cycle, pointer parks at 3.
    do_reset(4'b1011, 4'h0);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step(4'b1011, 4'h0, 0, 0, 0);
      @(negedge clk);
      check("solo_pop", 32'(pop), 32'h4);
      if (k > 0) check("solo_ptr", 32'(dut.ptr_q), 32'h3);
    end

    // FIFOs 0 and 2 paused: alternate between 1 and 3.
    alt_pops = '{2, 8, 2, 8};
    do_reset(4'h0, 4'b0101);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step(4'h0, 4'b0101, 0, 0, 0);
      @(negedge clk);
      check("pause_pop", 32'(pop), 32'(alt_pops[k]));
    end

    // Almost-full backpressure: two in-flight pushes drain, then resume.
    do_reset(4'h0, 4'h0);
    for (int k = 1; k < 4; k++) step(4'h0, 4'h0, 0, 0, 0);
    step(4'h0, 4'h0, 1, 0, 0);
    @(negedge clk);
    check("af_pop0",  32'(pop),  32'h0);
    check("af_push0", 32'(push), 32'h1);
    step(4'h0, 4'h0, 1, 0, 0);
    @(negedge clk);
    check("af_push1", 32'(push), 32'h1);
    step(4'h0, 4'h0, 1, 0, 0);
    @(negedge clk);
    check("af_push2", 32'(push), 32'h0);
    step(4'h0, 4'h0, 0, 0, 0);
    @(negedge clk);
    check("af_resume",   32'(pop != 4'h0), 32'h1);
    check("af_drop_err", 32'(drop_err),    32'h0);

    // error_full mid-stream: no pop that cycle, two draining pushes, HALT sticks.
    do_reset(4'h0, 4'h0);
    for (int k = 1; k < 3; k++) step(4'h0, 4'h0, 0, 0, 0);
    step(4'h0, 4'h0, 0, 1, 0);
    @(negedge clk);
    check("ef_pop",   32'(pop),  32'h0);
    check("ef_push0", 32'(push), 32'h1);
    step(4'h0, 4'h0, 0, 0, 0);
    @(negedge clk);
    check("ef_push1", 32'(push), 32'h1);
    for (int k = 0; k < 3; k++) begin
      step(4'h0, 4'h0, 0, 0, 0);
      @(negedge clk);
      check("halt_push", 32'(push),     32'h0);
      check("halt_pop",  32'(pop),      32'h0);
      check("halt_idle", 32'(arb_idle), 32'h0);
    end

    // Reset pulse with words in flight: cleared asynchronously.
    do_reset(4'h0, 4'h0);
    for (int k = 1; k < 4; k++) step(4'h0, 4'h0, 0, 0, 0);
    #2;
    check("pre_rst_push", 32'(push), 32'h1);
    reset = 1'b1;
    #1;
    check("async_push",     32'(push),      32'h0);
    check("async_data_out", 32'(data_out),  32'h0);
    check("async_ptr",      32'(dut.ptr_q), 32'h0);
    empty = 4'hF;
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("post_rst_idle", 32'(arb_idle), 32'h1);

    // Randomized traffic checked cycle by cycle by the model.
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 499) begin
        do_reset(4'($urandom), 4'h0);
      end else begin
        step(4'($urandom) & 4'($urandom),
             ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0,
             ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 299) == 0),
             ($urandom_range(0, 9) == 0));
      end
    end

    @(negedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_arbitro_rr
